bcd_scan_display: RTL and testbench

Time-multiplexed 7-segment display driver that consumes the packed BCD digits produced by the project's BCD counter. It is the reader side of the counter's BCD output bus. It snapshots the digits on a load strobe and commits them tear-free at frame boundaries. It then scans them one digit at a time onto a shared segment bus with one-hot digit enables. It sits between the counter core and the `uo_out`/`uio_out` pin mapping in the top-level wrapper.

---
 rtl/bcd_scan_display.sv | 166 ++++++++++++++++
 tb/tb_bcd_scan_display.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_display.sv
// Multiplexed 7-segment scanner for packed BCD digits with tear-free frame commit.
// Optional leading-zero blanking: define BCD_LZB_EN.
module bcd_scan_display #(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 1000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ena,
   input  logic [4*DIGITS-1:0]   bcd_in,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic                  load,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [DIGITS-1:0]     an,
   output logic                  frame_done,
   output logic                  err
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
   localparam logic [IW-1:0] I_LAST = IW'(DIGITS - 1);

   logic [PW-1:0]         pcnt_q, pcnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [4*DIGITS-1:0]   shadow_q, shadow_d;
   logic [DIGITS-1:0]     shadow_dp_q, shadow_dp_d;
   logic [4*DIGITS-1:0]   pend_q, pend_d;
   logic [DIGITS-1:0]     pend_dp_q, pend_dp_d;
   logic                  pend_v_q, pend_v_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic [DIGITS-1:0]     an_q, an_d;
   logic                  fd_q, fd_d;
   logic                  err_q, err_d;

   logic [3:0]            dig_a [DIGITS];
   logic [3:0]            digit;
   logic [6:0]            enc;
   logic                  last_slot;
   logic                  wrap;
   logic                  blank;

   always_comb begin
      for (int k = 0; k < DIGITS; k++) begin
         dig_a[k] = shadow_q[4*k +: 4];
      end
   end

`ifdef BCD_LZB_EN
   // hi_zero[k]: digit k and every digit above it are zero
   logic [DIGITS-1:0] hi_zero;
   always_comb begin
      hi_zero = '0;
      hi_zero[DIGITS-1] = (dig_a[DIGITS-1] == 4'd0);
      for (int k = DIGITS - 2; k >= 0; k--) begin
         hi_zero[k] = hi_zero[k+1] && (dig_a[k] == 4'd0);
      end
      blank = (idx_q != '0) && hi_zero[idx_q];
   end
`else
   assign blank = 1'b0;
`endif

   always_comb begin
      digit = dig_a[idx_q];
      case (digit)
         4'd0:    enc = 7'h3F;
         4'd1:    enc = 7'h06;
         4'd2:    enc = 7'h5B;
         4'd3:    enc = 7'h4F;
         4'd4:    enc = 7'h66;
         4'd5:    enc = 7'h6D;
         4'd6:    enc = 7'h7D;
         4'd7:    enc = 7'h07;
         4'd8:    enc = 7'h7F;
         4'd9:    enc = 7'h6F;
         default: enc = 7'h40;
      endcase
   end

   always_comb begin
      pcnt_d      = pcnt_q;
      idx_d       = idx_q;
      shadow_d    = shadow_q;
      shadow_dp_d = shadow_dp_q;
      pend_d      = pend_q;
      pend_dp_d   = pend_dp_q;
      pend_v_d    = pend_v_q;
      seg_d       = 7'h00;
      dp_d        = 1'b0;
      an_d        = '0;
      err_d       = 1'b0;

      last_slot = (pcnt_q == P_LAST);
      wrap      = ena && last_slot && (idx_q == I_LAST);
      fd_d      = wrap;

      if (ena) begin
         pcnt_d = last_slot ? '0 : pcnt_q + 1'b1;
         if (last_slot) begin
            idx_d = (idx_q == I_LAST) ? '0 : idx_q + 1'b1;
         end
      end

      // A load coinciding with the wrap goes straight to the shadow
      if (load && wrap) begin
         shadow_d    = bcd_in;
         shadow_dp_d = dp_in;
         pend_v_d    = 1'b0;
      end else if (load) begin
         pend_d    = bcd_in;
         pend_dp_d = dp_in;
         pend_v_d  = 1'b1;
      end else if (wrap && pend_v_q) begin
         shadow_d    = pend_q;
         shadow_dp_d = pend_dp_q;
         pend_v_d    = 1'b0;
      end

      if (ena && (pcnt_q != '0)) begin
         an_d  = DIGITS'(1) << idx_q;
         seg_d = blank ? 7'h00 : enc;
         dp_d  = shadow_dp_q[idx_q];
         err_d = !blank && (digit > 4'd9);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcnt_q      <= '0;
         idx_q       <= '0;
         shadow_q    <= '0;
         shadow_dp_q <= '0;
         pend_q      <= '0;
         pend_dp_q   <= '0;
         pend_v_q    <= 1'b0;
         seg_q       <= 7'h00;
         dp_q        <= 1'b0;
         an_q        <= '0;
         fd_q        <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         pcnt_q      <= pcnt_d;
         idx_q       <= idx_d;
         shadow_q    <= shadow_d;
         shadow_dp_q <= shadow_dp_d;
         pend_q      <= pend_d;
         pend_dp_q   <= pend_dp_d;
         pend_v_q    <= pend_v_d;
         seg_q       <= seg_d;
         dp_q        <= dp_d;
         an_q        <= an_d;
         fd_q        <= fd_d;
         err_q       <= err_d;
      end
   end

   assign seg        = seg_q;
   assign dp         = dp_q;
   assign an         = an_q;
   assign frame_done = fd_q;
   assign err        = err_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Randomized and directed bench for bcd_scan_display against a cycle-count model.
module tb_bcd_scan_display;

   localparam int D = 4;
   localparam int P = 4;
   localparam int F = D * P;

   logic          clk = 1'b0;
   logic          rst;
   logic          ena;
   logic          load;
   logic [15:0]   bcd_in;
   logic [3:0]    dp_in;
   logic [6:0]    seg;
   logic          dp;
   logic [3:0]    an;
   logic          frame_done;
   logic          err;

   bcd_scan_display #(.DIGITS(D), .PRESCALE(P)) dut (
      .clk(clk), .rst(rst), .ena(ena), .bcd_in(bcd_in), .dp_in(dp_in),
      .load(load), .seg(seg), .dp(dp), .an(an),
      .frame_done(frame_done), .err(err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: t counts enabled cycles since reset; slot position is plain arithmetic on t
   int          t;
   logic [15:0] m_sh, m_pend;
   logic [3:0]  m_shdp, m_penddp;
   bit          m_pv;

   logic [6:0] seg_tab [16];
   initial begin
      seg_tab[0] = 7'h3F; seg_tab[1] = 7'h06; seg_tab[2] = 7'h5B;
      seg_tab[3] = 7'h4F; seg_tab[4] = 7'h66; seg_tab[5] = 7'h6D;
      seg_tab[6] = 7'h7D; seg_tab[7] = 7'h07; seg_tab[8] = 7'h7F;
      seg_tab[9] = 7'h6F;
      for (int v = 10; v < 16; v++) seg_tab[v] = 7'h40;
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h t=%0d", tag, obs, exp, t);
      end
   endtask

   task automatic model_reset();
      t = 0; m_sh = '0; m_pend = '0; m_shdp = '0; m_penddp = '0; m_pv = 0;
   endtask

   function automatic bit is_blank(input int i, input logic [15:0] sh);
      bit b;
      b = 0;
`ifdef BCD_LZB_EN
      if (i != 0) begin
         b = 1;
         for (int k = i; k < D; k++) if (sh[4*k +: 4] != 4'd0) b = 0;
      end
`endif
      return b;
   endfunction

   // One clock: predict outputs from pre-edge model state, then advance model
   task automatic step();
      int p, i;
      bit wrap;
      logic [3:0] dg;
      logic [6:0] e_seg;
      logic e_dp, e_fd, e_err;
      logic [3:0] e_an;
      p = t % P;
      i = (t / P) % D;
      wrap = ena && (p == P - 1) && (i == D - 1);
      e_seg = 0; e_dp = 0; e_an = 0; e_err = 0; e_fd = wrap;
      if (ena && p != 0) begin
         dg = m_sh[4*i +: 4];
         e_an = 4'(1 << i);
         e_seg = is_blank(i, m_sh) ? 7'h00 : seg_tab[dg];
         e_dp = m_shdp[i];
         e_err = !is_blank(i, m_sh) && (dg > 9);
      end
      if (load && wrap) begin
         m_sh = bcd_in; m_shdp = dp_in; m_pv = 0;
      end else if (load) begin
         m_pend = bcd_in; m_penddp = dp_in; m_pv = 1;
      end else if (wrap && m_pv) begin
         m_sh = m_pend; m_shdp = m_penddp; m_pv = 0;
      end
      if (ena) t++;
      @(posedge clk);
      #1;
      check("an", 32'(an), 32'(e_an));
      check("seg", 32'(seg), 32'(e_seg));
      check("dp", 32'(dp), 32'(e_dp));
      check("err", 32'(err), 32'(e_err));
      check("frame_done", 32'(frame_done), 32'(e_fd));
      load = 0;
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic run_until(input int pos);
      int guard;
      guard = 0;
      while ((t % F) != pos && guard < 4 * F) begin
         step();
         guard++;
      end
      check("run_until_reached", 32'(t % F), 32'(pos));
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d);
      bcd_in = v; dp_in = d; load = 1;
      step();
   endtask

   initial begin
      rst = 1; ena = 1; load = 0; bcd_in = '0; dp_in = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_an", 32'(an), 0);
      check("rst_seg", 32'(seg), 0);
      check("rst_fd", 32'(frame_done), 0);
      rst = 0;

      run(40);

      run_until(5);
      do_load(16'h1234, 4'b0000);
      run(40);

      run_until(F - 1);
      do_load(16'h0907, 4'b0101);
      run(20);

      do_load(16'h00A5, 4'b0010);
      run(40);

      run_until(9);
      ena = 0;
      run(10);
      ena = 1;
      run(20);

      for (int k = 0; k < 300; k++) begin
         ena = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 7) == 0) begin
            bcd_in = 16'($urandom);
            dp_in = 4'($urandom);
            load = 1;
         end
         step();
      end
      ena = 1;

      do_load(16'h5678, 4'b1111);
      run_until(13);
      do_load(16'h4321, 4'b0011);
      rst = 1;
      #2;
      check("async_an", 32'(an), 0);
      check("async_seg", 32'(seg), 0);
      check("async_dp", 32'(dp), 0);
      check("async_err", 32'(err), 0);
      @(posedge clk);
      #1;
      rst = 0;
      model_reset();
      run(40);

      for (int k = 0; k < 100; k++) begin
         if ($urandom_range(0, 5) == 0) begin
            bcd_in = 16'($urandom);
            dp_in = 4'($urandom);
            load = 1;
         end
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
